// File: rtl/mvm_stream_par.sv
// Streaming K x K matrix-vector multiplier: y = A * x.
// A and x are loaded over a valid/ready beat stream and stay resident.
// start runs P MAC lanes over one row chunk per cycle, then streams y out.
// Datapath: registered memory read -> product register -> adder tree/accumulate.
module mvm_stream_par #(
    parameter int K  = 16,
    parameter int P  = 2,
    parameter int B  = 8,
    parameter int AW = 2*B + $clog2(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_matrix,
    input  logic                 load_vector,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [B-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err
);
    localparam int NCH    = K / P;            // cycles per row
    localparam int ISSUES = K * K / P;        // total issue cycles
    localparam int KW     = $clog2(K);
    localparam int CHB    = $clog2(NCH);
    localparam int CW     = $clog2(K*K) + 1;
    localparam int PW     = 2*B;

    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_LAST_A  = CW'(K*K - 1);
    localparam logic [CW-1:0] C_LAST_K  = CW'(K - 1);
    localparam logic [CW-1:0] C_ISSUES  = CW'(ISSUES);
    // Two extra cycles let the last row drain through product and accumulate stages.
    localparam logic [CW-1:0] C_DRAIN   = CW'(ISSUES + 1);
    localparam logic [CW-1:0] C_CHMASK  = CW'(NCH - 1);
    localparam logic [CW-1:0] C_P       = CW'(P);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT} state_t;

    state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;

    // Storage arrays deliberately have no reset so A, x and y survive it.
    logic signed [B-1:0]  r_mem_a [K*K];
    logic signed [B-1:0]  r_mem_x [K];
    logic signed [AW-1:0] r_mem_y [K];

    logic                 r_cmd_err, r_done;
    logic                 w_in_fire, w_out_fire, w_cmd, w_issue;
    logic                 w_first, w_lastc;
    logic [CW-1:0]        w_chunk;
    logic [KW-1:0]        w_row, w_col0;
    logic [P-1:0][KW-1:0] w_col;

    logic [P-1:0][B-1:0]  r_a_op, r_x_op;
    logic [P-1:0][PW-1:0] r_prod;
    logic [1:0]           r_vld_pipe;
    logic [1:0]           r_first_pipe, r_last_pipe;
    logic [1:0][KW-1:0]   r_row_pipe;
    logic signed [AW-1:0] r_acc, w_psum, w_acc_nxt;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_cmd      = start || load_matrix || load_vector;
    assign w_issue    = (r_state == COMPUTE) && (r_cnt < C_ISSUES);
    assign w_chunk    = r_cnt & C_CHMASK;
    assign w_row      = r_cnt[CHB +: KW];
    assign w_col0     = KW'(w_chunk * C_P);
    assign w_first    = (w_chunk == '0);
    assign w_lastc    = (w_chunk == C_CHMASK);
    assign cmd_err    = r_cmd_err;
    assign done       = r_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start)            w_state_nxt = COMPUTE;
                else if (load_matrix) w_state_nxt = LOAD_A;
                else if (load_vector) w_state_nxt = LOAD_X;
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (w_in_fire && r_cnt == C_LAST_A) w_state_nxt = IDLE;
            end
            LOAD_X: begin
                in_ready = 1'b1;
                if (w_in_fire && r_cnt == C_LAST_K) w_state_nxt = IDLE;
            end
            COMPUTE: begin
                if (r_cnt == C_DRAIN) w_state_nxt = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_last  = (r_cnt == C_LAST_K);
                out_data  = r_mem_y[r_cnt[KW-1:0]];
                if (w_out_fire && out_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shared counter: beat index in loads, cycle index in compute, y index in output.
    always_ff @(posedge clk) begin
        if (reset)                                           r_cnt <= '0;
        else if (w_state_nxt != r_state)                     r_cnt <= '0;
        else if (r_state == COMPUTE || w_in_fire || w_out_fire) r_cnt <= r_cnt + C_ONE;
    end

    // Command rejection and completion pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cmd_err <= (r_state != IDLE) && w_cmd;
            r_done    <= w_out_fire && out_last;
        end
    end

    // Load A (row-major) and x from the input stream.
    always_ff @(posedge clk) begin
        if (!reset && r_state == LOAD_A && in_valid) r_mem_a[r_cnt[2*KW-1:0]] <= in_data;
        if (!reset && r_state == LOAD_X && in_valid) r_mem_x[r_cnt[KW-1:0]]   <= in_data;
    end

    // Lane column addresses for the current chunk.
    always_comb begin
        w_col = '0;
        for (int p = 0; p < P; p++) w_col[p] = w_col0 + KW'(p);
    end

    // Stage 1 operand fetch and stage 2 products, one per lane.
    always_ff @(posedge clk) begin
        for (int p = 0; p < P; p++) begin
            r_a_op[p] <= r_mem_a[{w_row, w_col[p]}];
            r_x_op[p] <= r_mem_x[w_col[p]];
            r_prod[p] <= PW'($signed(r_a_op[p])) * PW'($signed(r_x_op[p]));
        end
    end

    // Valid shift register: [0] operands valid, [1] products valid.
    always_ff @(posedge clk) begin
        if (reset) r_vld_pipe <= '0;
        else       r_vld_pipe <= {r_vld_pipe[0], w_issue};
    end

    // Row start/end markers and row index travel alongside the data.
    always_ff @(posedge clk) begin
        r_first_pipe <= {r_first_pipe[0], w_first};
        r_last_pipe  <= {r_last_pipe[0], w_lastc};
        r_row_pipe   <= {r_row_pipe[0], w_row};
    end

    // Adder tree over lanes; row start restarts the sum instead of adding.
    always_comb begin
        w_psum = '0;
        for (int p = 0; p < P; p++) w_psum = w_psum + AW'($signed(r_prod[p]));
        w_acc_nxt = r_first_pipe[1] ? w_psum : r_acc + w_psum;
    end

    // Accumulate and retire each completed row into the result buffer.
    always_ff @(posedge clk) begin
        if (!reset && r_vld_pipe[1]) begin
            r_acc <= w_acc_nxt;
            if (r_last_pipe[1]) r_mem_y[r_row_pipe[1]] <= w_acc_nxt;
        end
    end
endmodule

// File: tb/tb_mvm_stream_par.sv
// Randomized bench for mvm_stream_par: loads A/x with random stalls, runs
// y = A*x, and checks the output stream against a plain-arithmetic model.
module tb_mvm_stream_par;
    localparam int K   = 16;
    localparam int P   = 2;
    localparam int B   = 8;
    localparam int AW  = 2*B + $clog2(K);
    localparam int LAT = K*K/P + 3;

    logic clk = 1'b0, reset = 1'b1;
    logic load_matrix = 1'b0, load_vector = 1'b0, start = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic signed [B-1:0] in_data = '0;
    logic in_ready, out_valid, out_last, busy, done, cmd_err;
    logic signed [AW-1:0] out_data;

    mvm_stream_par #(.K(K), .P(P), .B(B)) dut (
        .clk(clk), .reset(reset), .load_matrix(load_matrix), .load_vector(load_vector),
        .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    int     ma [K][K];
    int     mx [K];
    longint q[$];
    int     start_cyc = 0;
    bit     exp_active = 0, done_exp = 0, prev_stall = 0;
    logic signed [63:0] prev_data = '0;
    int     n_chk = 0, n_fail = 0;
    int     rdy_mode = 0, ph = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic void build_exp();
        q.delete();
        for (int r = 0; r < K; r++) begin
            longint s = 0;
            for (int c = 0; c < K; c++) s += longint'(ma[r][c]) * longint'(mx[c]);
            q.push_back(s);
        end
    endfunction

    // out_ready pattern generator
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ph % 3 == 0);
            default: out_ready = 1'($urandom_range(1));
        endcase
        ph++;
    end

    // Compare process: checks outputs against the model every cycle.
    always @(negedge clk) begin
        if (reset) begin
            q.delete(); exp_active = 0; done_exp = 0; prev_stall = 0;
        end else begin
            chk("done", done, done_exp);
            done_exp = 0;
            if (exp_active) begin
                chk("in_ready_busy", in_ready, 0);
                if (cyc - start_cyc < LAT)       chk("early_valid", out_valid, 0);
                else if (cyc - start_cyc == LAT) chk("first_valid_latency", out_valid, 1);
            end
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_valid", out_valid, 0);
                else begin
                    chk("y_data", out_data, q[0]);
                    chk("y_last", out_last, q.size() == 1);
                    if (prev_stall) chk("stall_hold", out_data, prev_data);
                    if (out_ready) begin
                        q.delete(0);
                        if (q.size() == 0) begin done_exp = 1; exp_active = 0; end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send_beat(input int v);
        bit acc = 0;
        for (int g = 0; g < 64 && !acc; g++) begin
            in_valid = ($urandom_range(3) != 0);
            in_data  = B'(v);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("beat_accept", acc, 1);
    endtask

    task automatic load_a(input int err_at);
        load_matrix = 1'b1; tick(); load_matrix = 1'b0;
        chk("ldA_ready", in_ready, 1);
        for (int i = 0; i < K*K; i++) begin
            if (i == err_at) begin
                start = 1'b1; tick(); start = 1'b0;
                chk("ldA_cmd_err", cmd_err, 1);
                chk("ldA_still_ready", in_ready, 1);
            end
            send_beat(ma[i / K][i % K]);
        end
        chk("ldA_idle", busy, 0);
    endtask

    task automatic load_x();
        load_vector = 1'b1; tick(); load_vector = 1'b0;
        chk("ldX_ready", in_ready, 1);
        for (int i = 0; i < K; i++) send_beat(mx[i]);
        chk("ldX_idle", busy, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        build_exp();
        start_cyc  = cyc;
        exp_active = 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (exp_active && g < 3000) begin tick(); g++; end
        chk("run_complete", exp_active, 0);
        chk("idle_after_last", busy, 0);
        tick();
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_last"}, out_last, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_cmd_err"}, cmd_err, 0);
        chk({nm, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk_quiet("reset");

        // Identity A, x = 1..16, always ready
        for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) ma[r][c] = (r == c) ? 1 : 0;
        for (int c = 0; c < K; c++) mx[c] = c + 1;
        load_a(-1);
        load_x();
        rdy_mode = 0;
        do_start();
        chk("pin_id_y0", q[0], 1);
        chk("pin_id_y15", q[K-1], 16);
        wait_idle();

        // Same with out_ready 1,0,0 pattern
        rdy_mode = 1; ph = 0;
        do_start();
        wait_idle();
        rdy_mode = 0;

        // load_matrix during COMPUTE is rejected
        do_start();
        repeat (40) tick();
        chk("cmd_err_pre", cmd_err, 0);
        load_matrix = 1'b1; tick(); load_matrix = 1'b0;
        chk("cmd_err_pulse", cmd_err, 1);
        chk("cmd_err_busy", busy, 1);
        tick();
        chk("cmd_err_once", cmd_err, 0);
        wait_idle();

        // Reset 50 cycles into COMPUTE, then rerun from retained A/x
        do_start();
        repeat (50) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk_quiet("midreset");
        repeat (5) tick();
        do_start();
        wait_idle();

        // Reload x only = 16..1
        for (int c = 0; c < K; c++) mx[c] = K - c;
        load_x();
        do_start();
        chk("pin_rev_y0", q[0], 16);
        chk("pin_rev_y15", q[K-1], 1);
        wait_idle();

        // Extremes: -128 * -128, with a rejected start mid-load
        for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) ma[r][c] = -128;
        for (int c = 0; c < K; c++) mx[c] = -128;
        load_a(100);
        load_x();
        do_start();
        chk("pin_neg_y7", q[7], 262144);
        wait_idle();

        // 127 * -128
        for (int r = 0; r < K; r++) for (int c = 0; c < K; c++) ma[r][c] = 127;
        load_a(-1);
        do_start();
        chk("pin_mix_y3", q[3], -260096);
        wait_idle();

        // Random A/x with random backpressure
        rdy_mode = 2;
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) ma[r][c] = int'($urandom_range(255)) - 128;
            for (int c = 0; c < K; c++) mx[c] = int'($urandom_range(255)) - 128;
            load_a(-1);
            load_x();
            do_start();
            wait_idle();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mvm_stream_par.md
MVM_STREAM_PAR -- requirements
Module: mvm_stream_par

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  K, 16, matrix dimension (K x K matrix A, K-element vectors x and y); power of 2, >= 2.
  P, 2, parallel MAC lanes; power of 2, divides K.
  B, 8, signed input element width.
  AW (derived), 2*B+$clog2(K), signed accumulator and output width.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock.
  reset  in  1  reset; synchronous, active-high.
  load_matrix  in  1  command: load A.
  load_vector  in  1  command: load x.
  start  in  1  command: compute y = A*x.
  in_valid  in  1  input beat valid.
  in_ready  out  1  input beat accepted when in_valid && in_ready.
  in_data  in  B  signed input element.
  out_valid  out  1  output beat valid.
  out_ready  in  1  downstream ready.
  out_data  out  AW  signed y element.
  out_last  out  1  marks y[K-1].
  busy  out  1  high in every state except IDLE.
  done  out  1  one-cycle completion pulse.
  cmd_err  out  1  one-cycle pulse: command rejected.
REQ-003 Reset SHALL be reset: synchronous, active-high; clock SHALL be clk.

Function
REQ-004 States SHALL be IDLE, LOAD_A, LOAD_X, COMPUTE, OUTPUT.
REQ-005 In IDLE, commands SHALL be sampled with priority start > load_matrix > load_vector; the selected command moves to COMPUTE, LOAD_A or LOAD_X on the next edge.
REQ-006 A command asserted outside IDLE SHALL be ignored and SHALL produce a cmd_err pulse the following cycle; state, memories and outputs are unaffected.
REQ-007 in_ready SHALL be high only in LOAD_A and LOAD_X.
REQ-008 LOAD_A SHALL accept exactly K*K beats, row-major (beat r*K+c = A[r][c]); after the last beat it returns to IDLE. There is no timeout.
REQ-009 LOAD_X SHALL accept exactly K beats (beat c = x[c]); after the last beat it returns to IDLE.
REQ-010 Stalls (in_valid low) SHALL not advance load counters.
REQ-011 A and x SHALL be retained across commands, so either may be reloaded independently.
REQ-012 COMPUTE SHALL consume P products of one row per cycle, taking K/P cycles per row and K*K/P issue cycles in total.
REQ-013 The multiply path SHALL be registered: memory read, then product register, then adder-tree/accumulate.
REQ-014 Products SHALL be full-precision signed B x B. Accumulation SHALL be signed AW bits, which cannot overflow.
REQ-015 The accumulator SHALL clear at each row start, with no bubble between rows.
REQ-016 Completed y[r] SHALL be written to an internal K-entry result buffer.
REQ-017 The first out_valid SHALL assert exactly K*K/P+3 cycles after the cycle in which start is sampled in IDLE.
REQ-018 OUTPUT SHALL emit y[0]..y[K-1] in order, one per out_valid && out_ready handshake. out_last SHALL be high with y[K-1].
REQ-019 While out_valid && !out_ready, out_data and out_last SHALL hold stable.
REQ-020 Output beats SHALL never be dropped or duplicated.
REQ-021 OUTPUT MAY begin while COMPUTE rows remain, provided order and REQ-017 hold. The FSM enters IDLE only after the y[K-1] handshake.
REQ-022 done SHALL pulse for one cycle, on the cycle after the y[K-1] handshake, coincident with return to IDLE.
REQ-023 start with unloaded memories SHALL still compute, on undefined data; there is no error.

Reset
REQ-024 On reset, state SHALL be IDLE and all counters zero.
REQ-025 On reset, in_ready, out_valid, out_last, busy, done and cmd_err SHALL be 0, and out_data SHALL be 0.
REQ-026 Reset mid-operation SHALL abort within one cycle, with no partial output beats after reset.
REQ-027 Reset SHALL NOT clear the A, x or y storage arrays.

Verification (K=16, P=2, B=8, AW=20)
REQ-028 A = identity, x = 1..16, start, out_ready=1 -> y = 1..16; first out_valid 131 cycles after start; done 1 cycle after y[15].
REQ-029 A all -128, x all -128 -> every y = 262144; A all 127, x all -128 -> every y = -260096.
REQ-030 Identity case with out_ready toggling 1,0,0,1,... -> same 16 values in order, out_data stable during stalls, out_last only on y[15].
REQ-031 load_matrix pulsed during COMPUTE -> cmd_err pulses once, results identical to the unperturbed run, state never enters LOAD_A.
REQ-032 Reset 50 cycles into COMPUTE -> all outputs 0 next cycle; then start without reload -> correct y from retained A and x.
REQ-033 Reload only x = 16..1 with A = identity retained -> y = 16..1.
